// File: rtl/uart_rx_frame_timer.sv
// uart_rx_frame_timer: per-bit edge/bit counters, mid-bit sample strobes and frame_end for a UART receiver.
// Optional two-stop-bit support (stop2 port) when UART_RX_STOP2_EN is defined.
module uart_rx_frame_timer #(
  parameter int PRESC_W = 6,
  parameter int DATA_W  = 8,
  parameter int BIT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic               par_en,
`ifdef UART_RX_STOP2_EN
  input  logic               stop2,
`endif
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sample_stb,
  output logic [1:0]         sample_idx,
  output logic               bit_end,
  output logic               frame_end,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [PRESC_W-1:0] edge_n, p_q, p_n, half, off;
  logic [BIT_W-1:0] bit_n, last;
  logic par_q, par_n;
`ifdef UART_RX_STOP2_EN
  logic stop2_q, stop2_n;
  assign last = BIT_W'(DATA_W + 1) + BIT_W'(par_q) + BIT_W'(stop2_q);
`else
  assign last = BIT_W'(DATA_W + 1) + BIT_W'(par_q);
`endif
  assign half       = p_q >> 1;
  // Offset from the first sample point; edges before it wrap to large values.
  assign off        = edge_cnt - (half - PRESC_W'(1));
  assign busy       = state == RUN;
  assign bit_end    = busy && edge_cnt == p_q - PRESC_W'(1);
  assign frame_end  = bit_end && bit_cnt == last;
  assign sample_stb = busy && off <= PRESC_W'(2);
  assign sample_idx = sample_stb ? off[1:0] : 2'd0;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      p_q      <= '0;
      par_q    <= 1'b0;
`ifdef UART_RX_STOP2_EN
      stop2_q  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      edge_cnt <= edge_n;
      bit_cnt  <= bit_n;
      p_q      <= p_n;
      par_q    <= par_n;
`ifdef UART_RX_STOP2_EN
      stop2_q  <= stop2_n;
`endif
    end
  always_comb begin
    state_n = state;
    edge_n  = edge_cnt;
    bit_n   = bit_cnt;
    p_n     = p_q;
    par_n   = par_q;
`ifdef UART_RX_STOP2_EN
    stop2_n = stop2_q;
`endif
    if (!enable) begin
      state_n = IDLE;
      edge_n  = '0;
      bit_n   = '0;
    end else if (state == IDLE) begin
      state_n = RUN;
      edge_n  = PRESC_W'(1);
      bit_n   = '0;
      p_n     = prescale < PRESC_W'(4) ? PRESC_W'(4) : prescale;
      par_n   = par_en;
`ifdef UART_RX_STOP2_EN
      stop2_n = stop2;
`endif
    end else if (frame_end) begin
      state_n = DONE;
      edge_n  = '0;
      bit_n   = '0;
    end else if (bit_end) begin
      edge_n = '0;
      bit_n  = bit_cnt + BIT_W'(1);
    end else if (state == RUN) begin
      edge_n = edge_cnt + PRESC_W'(1);
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// tb_uart_rx_frame_timer: directed frame scenarios checked cycle by cycle against hand-derived timing.
module tb_uart_rx_frame_timer;
  logic CLK = 0, RST = 1, enable = 0, par_en = 0, stop2 = 0;
  logic [5:0] prescale = 6'd8;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic sample_stb, bit_end, frame_end, busy;
  logic [1:0] sample_idx;
  logic [15:0] act;
  int tests = 0, fails = 0;

  uart_rx_frame_timer dut (
    .CLK(CLK), .RST(RST), .enable(enable), .par_en(par_en),
`ifdef UART_RX_STOP2_EN
    .stop2(stop2),
`endif
    .prescale(prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sample_stb(sample_stb), .sample_idx(sample_idx), .bit_end(bit_end),
    .frame_end(frame_end), .busy(busy)
  );

  always #5 CLK = ~CLK;
  assign act = {busy, bit_cnt, edge_cnt, sample_stb, sample_idx, bit_end, frame_end};

  // Starts from IDLE at a negedge; config inputs are disturbed at cycle 20 to prove they are latched.
  task automatic run_frame(input int p_in, input bit par, input bit st, input int last, input string name);
    int p, total, pos, e, b, m;
    logic stb;
    logic [1:0] idx;
    logic [15:0] exp_v;
    p = p_in < 4 ? 4 : p_in;
    total = (last + 1) * p;
    m = p / 2;
    prescale = 6'(p_in);
    par_en = par;
    stop2 = st;
    enable = 1;
    for (int c = 2; c <= total + 5; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (c <= total) begin
        pos = c - 1;
        e = pos % p;
        b = pos / p;
        stb = e >= m - 1 && e <= m + 1;
        idx = stb ? 2'(e - m + 1) : 2'd0;
        exp_v = {1'b1, 4'(b), 6'(e), stb, idx, e == p - 1, e == p - 1 && b == last};
      end else exp_v = '0;
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp_v);
      end
      if (c == 20) begin
        par_en = !par;
        stop2 = !st;
        prescale = 6'd16;
      end
    end
    enable = 0;
    @(posedge CLK);
    @(negedge CLK);
    tests++;
    if (act !== 16'h0) begin
      fails++;
      $display("FAIL %s idle_after: got %h expected 0000", name, act);
    end
  endtask

  task automatic test_reset();
    enable = 1;
    #2;
    tests++;
    if (act !== 16'h0) begin
      fails++;
      $display("FAIL reset_initial: got %h expected 0000", act);
    end
    @(posedge CLK);
    @(negedge CLK);
    tests++;
    if (act !== 16'h0) begin
      fails++;
      $display("FAIL reset_held: got %h expected 0000", act);
    end
    enable = 0;
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    run_frame(8, 0, 0, 9, "basic");
  endtask

  task automatic test_parity();
    run_frame(8, 1, 0, 10, "parity");
  endtask

  task automatic test_clamp();
    run_frame(2, 0, 0, 9, "clamp");
  endtask

  task automatic test_abort();
    prescale = 6'd8;
    par_en = 0;
    enable = 1;
    repeat (43) @(posedge CLK);
    @(negedge CLK);
    tests++;
    if (act !== {1'b1, 4'd5, 6'd3, 1'b1, 2'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_position: got %h expected bit 5 edge 3", act);
    end
    enable = 0;
    @(posedge CLK);
    @(negedge CLK);
    tests++;
    if (act !== 16'h0) begin
      fails++;
      $display("FAIL abort_idle: got %h expected 0000", act);
    end
    run_frame(8, 0, 0, 9, "restart");
  endtask

  task automatic test_reset_mid();
    prescale = 6'd8;
    par_en = 0;
    enable = 1;
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1;
    #1;
    tests++;
    if (act !== 16'h0) begin
      fails++;
      $display("FAIL reset_async: got %h expected 0000", act);
    end
    @(negedge CLK);
    RST = 0;
    @(posedge CLK);
    @(negedge CLK);
    tests++;
    if (act !== {1'b1, 4'd0, 6'd1, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_restart: got %h expected bit 0 edge 1 busy", act);
    end
    enable = 0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

`ifdef UART_RX_STOP2_EN
  task automatic test_stop2();
    run_frame(8, 1, 1, 11, "stop2");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_clamp();
    test_abort();
    test_reset_mid();
`ifdef UART_RX_STOP2_EN
    test_stop2();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
